// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use stalls,
// EX-resolved redirects, data-memory wait freezes, plus event counters and a timeout flag.
module hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rt_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       rt_EX,
  input  logic             redirect_EX,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             pc_redirect,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic mem_busy;
  logic load_use;
  logic do_redirect;
  logic do_stall;

  always_comb begin
    mem_busy    = mem_req_MEM & ~mem_ready;
    load_use    = MemRead_EX & (rt_EX != 5'd0) &
                  ((rt_EX == rs_ID) | (uses_rt_ID & (rt_EX == rt_ID)));
    do_redirect = ~mem_busy & redirect_EX;
    do_stall    = ~mem_busy & ~redirect_EX & load_use;
  end

  // Freeze beats redirect beats stall; while in reset the pipeline is filled with bubbles.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    pc_redirect  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redirect_EX) begin
      pc_redirect  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_timeout_d = mem_timeout_q;

    if (state_q == ST_RUN) begin
      wait_cnt_d = '0;
      if (mem_busy) state_d = ST_WAIT;
    end else begin
      if (!mem_busy) begin
        state_d = ST_RUN;
      end else if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    // Clear wins over any same-cycle increment or timeout set.
    if (cnt_clr) begin
      stall_cnt_d   = '0;
      flush_cnt_d   = '0;
      mem_timeout_d = 1'b0;
    end else begin
      if ((state_q == ST_WAIT) && mem_busy && (wait_cnt_d == WAIT_MAX))
        mem_timeout_d = 1'b1;
      if (do_stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_d = stall_cnt_q + 1'b1;
      if (do_redirect && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters (CNT_W=2) and MAX_WAIT=4;
// a reference model pushes expected results to a queue that is drained after each edge.
module tb_hazard_ctrl;

  localparam int CNT_W  = 2;
  localparam int MAX_W  = 4;
  localparam int CNT_MX = 3;

  logic             clk;
  logic             rst_n;
  logic [4:0]       rs_ID, rt_ID, rt_EX;
  logic             uses_rt_ID, MemRead_EX, redirect_EX, mem_req_MEM, mem_ready, cnt_clr;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic             pc_redirect, if_id_flush, id_ex_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout;
  logic [7:0]       ctl_vec;

  typedef struct packed {
    logic [7:0]       ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic             tmo;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  int   m_state, m_wait, m_stall, m_flush;
  logic m_tmo;

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
    .MemRead_EX(MemRead_EX), .rt_EX(rt_EX), .redirect_EX(redirect_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .pc_redirect(pc_redirect),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  assign ctl_vec = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                    pc_redirect, if_id_flush, id_ex_flush, mem_wb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_wait  = 0;
    m_stall = 0;
    m_flush = 0;
    m_tmo   = 1'b0;
  endtask

  // Drive one cycle of inputs, predict controls and post-edge counters, then check both.
  task automatic applyStimulus(input string tag,
                               input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                               input logic mrd, input logic [4:0] rte, input logic redir,
                               input logic req, input logic rdy, input logic clr);
    exp_t e;
    logic busy, lu;
    int   nw;
    @(negedge clk);
    rs_ID = rs; rt_ID = rt; uses_rt_ID = uses; MemRead_EX = mrd; rt_EX = rte;
    redirect_EX = redir; mem_req_MEM = req; mem_ready = rdy; cnt_clr = clr;

    busy = req & ~rdy;
    lu   = mrd && (rte != 5'd0) && ((rte == rs) || (uses && (rte == rt)));
    if (busy)       e.ctl = 8'b0000_0001;
    else if (redir) e.ctl = 8'b1111_1110;
    else if (lu)    e.ctl = 8'b0011_0010;
    else            e.ctl = 8'b1111_0000;

    if (m_state == 0) nw = 0;
    else if (busy)    nw = (m_wait < MAX_W) ? m_wait + 1 : m_wait;
    else              nw = m_wait;
    if (clr) begin
      m_stall = 0;
      m_flush = 0;
      m_tmo   = 1'b0;
    end else begin
      if ((m_state == 1) && busy && (nw == MAX_W)) m_tmo = 1'b1;
      if (!busy && redir && (m_flush < CNT_MX)) m_flush++;
      if (!busy && !redir && lu && (m_stall < CNT_MX)) m_stall++;
    end
    m_wait  = nw;
    m_state = busy ? 1 : 0;
    e.stall = CNT_W'(m_stall);
    e.flush = CNT_W'(m_flush);
    e.tmo   = m_tmo;
    expq.push_back(e);

    #1;
    checkOutput({tag, ".ctl"}, {24'd0, ctl_vec}, {24'd0, expq[0].ctl});
    @(posedge clk);
    #1;
    e = expq.pop_front();
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
    checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.flush));
    checkOutput({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(e.tmo));
  endtask

  initial begin
    rst_n = 1'b0;
    rs_ID = '0; rt_ID = '0; uses_rt_ID = 0; MemRead_EX = 0; rt_EX = '0;
    redirect_EX = 0; mem_req_MEM = 0; mem_ready = 0; cnt_clr = 0;
    modelReset();

    #3;
    checkOutput("reset.ctl", {24'd0, ctl_vec}, 32'h07);
    checkOutput("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("reset.flush_cnt", 32'(flush_cnt), 32'd0);
    checkOutput("reset.mem_timeout", 32'(mem_timeout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //              tag            rs  rt  use mrd rtEX red req rdy clr
    applyStimulus("normal",        1,  2,  1,  0,  0,   0,  0,  0,  0);
    applyStimulus("lu_rs",         8,  3,  0,  1,  8,   0,  0,  0,  0);
    applyStimulus("after_lu",      8,  3,  0,  0,  8,   0,  0,  0,  0);
    applyStimulus("load_r0",       0,  0,  1,  1,  0,   0,  0,  0,  0);
    applyStimulus("rt_no_use",     4,  9,  0,  1,  9,   0,  0,  0,  0);
    applyStimulus("rt_use",        4,  9,  1,  1,  9,   0,  0,  0,  0);
    applyStimulus("rdy_no_req",    1,  2,  1,  0,  0,   0,  0,  1,  0);
    applyStimulus("clr1",          1,  2,  1,  0,  0,   0,  0,  0,  1);
    checkOutput("clr1.stall_zero", 32'(stall_cnt), 32'd0);

    applyStimulus("beq_lu",        8,  3,  0,  1,  8,   1,  0,  0,  0);
    applyStimulus("normal2",       1,  2,  0,  0,  0,   0,  0,  0,  0);
    for (int i = 0; i < 3; i++)
      applyStimulus("frz_all",     8,  3,  0,  1,  8,   1,  1,  0,  0);
    applyStimulus("frz_release",   8,  3,  0,  1,  8,   1,  1,  1,  0);
    checkOutput("frz.flush_two", 32'(flush_cnt), 32'd2);
    applyStimulus("clr2",          1,  2,  0,  0,  0,   0,  0,  0,  1);

    for (int i = 0; i < 6; i++)
      applyStimulus("wait6",       1,  2,  0,  0,  0,   0,  1,  0,  0);
    applyStimulus("wait_done",     1,  2,  0,  0,  0,   0,  1,  1,  0);
    checkOutput("tmo_sticky", 32'(mem_timeout), 32'd1);
    applyStimulus("tmo_hold",      1,  2,  0,  0,  0,   0,  0,  0,  0);
    applyStimulus("tmo_clr",       1,  2,  0,  0,  0,   0,  0,  0,  1);

    for (int i = 0; i < 5; i++)
      applyStimulus("lu_sat",      5,  6,  1,  1,  6,   0,  0,  0,  0);
    checkOutput("lu_sat.value", 32'(stall_cnt), 32'd3);
    applyStimulus("beq_only",      1,  2,  0,  0,  0,   1,  0,  0,  0);

    for (int i = 0; i < 2; i++)
      applyStimulus("pre_rst_wait", 1, 2,  0,  0,  0,   1,  1,  0,  0);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_wait.ctl", {24'd0, ctl_vec}, 32'h07);
    checkOutput("rst_wait.stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("rst_wait.flush_cnt", 32'(flush_cnt), 32'd0);
    checkOutput("rst_wait.mem_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("post_rst",      1,  2,  0,  0,  0,   0,  0,  0,  0);
    for (int i = 0; i < 4; i++)
      applyStimulus("rewait",      1,  2,  0,  0,  0,   0,  1,  0,  0);
    applyStimulus("rewait_tmo",    1,  2,  0,  0,  0,   0,  1,  0,  0);
    applyStimulus("rewait_done",   1,  2,  0,  0,  0,   0,  0,  0,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS pipeline. Drives write-enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, covering three cases: load-use stalls, EX-resolved branch/jump redirects, and data-memory wait states. It also keeps saturating stall and flush event counters and raises a sticky memory-timeout flag. Sits beside the pipeline registers in the top level and takes its inputs from the ID, EX and MEM stages.

## Interface
- CNT_W, 16, width of the event counters
- MAX_WAIT, 64, number of consecutive memory-wait cycles after which the timeout flag sets (must be ≥1)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs_ID  in  5  rs field of the instruction in ID
- rt_ID  in  5  rt field of the instruction in ID
- uses_rt_ID  in  1  the ID instruction reads rt as a source
- MemRead_EX  in  1  the EX instruction is a load
- rt_EX  in  5  destination register of the EX load
- redirect_EX  in  1  taken branch (BranchEQ/BranchNE resolved) or Jump in EX
- mem_req_MEM  in  1  MemRead or MemWrite is active in MEM
- mem_ready  in  1  data memory completes the MEM access this cycle
- cnt_clr  in  1  synchronous clear of the counters and the timeout flag
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1 each  register load enables
- pc_redirect  out  1  PC mux selects the branch/jump target
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble (all control bits 0) instead of data
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  redirect events, saturating
- mem_timeout  out  1  sticky; a memory wait exceeded MAX_WAIT

## Operation
- Condition terms, evaluated every cycle:
  - mem_busy = mem_req_MEM & ~mem_ready
  - load_use = MemRead_EX & (rt_EX≠0) & ((rt_EX==rs_ID) | (uses_rt_ID & rt_EX==rt_ID))
- Priority: mem_busy > redirect_EX > load_use > normal.
- Normal: all *_write = 1; all flushes and pc_redirect = 0.
- mem_busy: pc_write, if_id_write, id_ex_write, ex_mem_write = 0; mem_wb_flush = 1; no flushes upstream. Any redirect_EX or load_use is held, because EX and ID are frozen. They are resolved in the first non-busy cycle.
- redirect_EX (not busy): pc_redirect = 1, pc_write = 1, if_id_flush = 1, id_ex_flush = 1, other writes = 1. load_use in the same cycle is ignored, since the ID instruction is killed anyway.
- load_use (no busy, no redirect): pc_write = 0, if_id_write = 0, id_ex_flush = 1, ex_mem_write = 1. This is a single bubble; the next cycle sees the load in MEM and load_use deasserts naturally.
- FSM with two states, RUN and WAIT:
  - RUN→WAIT when mem_busy.
  - WAIT→RUN when ~mem_busy.
  - All other transitions stay in the current state.
  - The outputs are combinational from the inputs. The FSM only drives the wait counter.
- Wait counter:
  - Cleared in RUN.
  - Increments each WAIT cycle in which mem_busy holds, saturating at MAX_WAIT.
  - When it reaches MAX_WAIT while still busy, mem_timeout sets on that edge and holds until cnt_clr or reset.
- Event counters:
  - stall_cnt increments on each cycle where the load_use action is applied.
  - flush_cnt increments on each cycle where the redirect action is applied.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr takes priority over an increment in the same cycle (result is 0).

## Timing
- Reset (rst_n low, asynchronous): state = RUN, wait counter = 0, stall_cnt = flush_cnt = 0, mem_timeout = 0.
- While rst_n is low, the outputs are forced: all *_write = 0, pc_redirect = 0, all flushes = 1, so the pipeline fills with bubbles.
- Control outputs have zero-cycle latency: they are combinational in the same cycle as the inputs.
- Counters and mem_timeout update on the rising edge after the qualifying cycle.
- Reset during WAIT: return immediately to RUN and clear the counter. A pending redirect is not remembered; the EX contents are reloaded after reset.
- Simultaneous mem_busy & redirect_EX & load_use: only the freeze is applied. Next non-busy cycle: redirect is applied and flush_cnt increments once; stall_cnt does not increment.
- mem_ready high with mem_req_MEM low is ignored.

## Test plan
- Load-use: lw $8 in EX, ID uses rs=8 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0→1; the next cycle is normal.
- Load to $0, or rt match with uses_rt_ID=0 → no stall; stall_cnt stays 0.
- Taken beq in EX together with a load-use hit → pc_redirect=1, if_id_flush=id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- mem_req_MEM=1, mem_ready=0 for 3 cycles with a redirect in EX → 3 frozen cycles with mem_wb_flush=1, then one redirect cycle; flush_cnt=1.
- MAX_WAIT=4 with mem_ready held low for 6 cycles → mem_timeout rises after the 4th wait cycle and stays 1 after ready; cnt_clr returns it to 0.
- Saturation: CNT_W=2 with 5 load-use stalls → stall_cnt=3. Then assert rst_n=0 mid-WAIT → all counters 0, flushes=1, writes=0 immediately.
